// File: rtl/ps2_key_decoder_if.sv
// Key-decoder bus: raw receiver byte strobe in, buffered calculator tokens out.
// The master side is the producer/consumer pair; the slave side is the decoder.
interface ps2_key_decoder_if;
  logic       iREADY_n;
  logic [7:0] iBYTE;
  logic       iKEY_POP;
  logic       oKEY_VALID;
  logic [3:0] oKEY_CODE;
  logic       oKEY_EXT;
  logic       oHELD;
  logic       oOVF;

  modport master (
    output iREADY_n, iBYTE, iKEY_POP,
    input  oKEY_VALID, oKEY_CODE, oKEY_EXT, oHELD, oOVF
  );

  modport slave (
    input  iREADY_n, iBYTE, iKEY_POP,
    output oKEY_VALID, oKEY_CODE, oKEY_EXT, oHELD, oOVF
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode stream to calculator key tokens: handles E0/F0 prefixes,
// suppresses typematic repeats and queues tokens in a small registered-head FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH      = 4,
  parameter int PREFIX_TIMEOUT  = 50000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  ps2_key_decoder_if.slave   bus
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int TW   = $clog2(PREFIX_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  // Returns {hit, token}; only Enter and '/' are shared by plain and E0 codes.
  function automatic logic [4:0] map_token(input logic [7:0] code, input logic ext);
    logic [4:0] r;
    r = 5'h00;
    unique case (code)
      8'h70, 8'h45: r = {!ext, 4'h0};
      8'h69, 8'h16: r = {!ext, 4'h1};
      8'h72, 8'h1E: r = {!ext, 4'h2};
      8'h7A, 8'h26: r = {!ext, 4'h3};
      8'h6B, 8'h25: r = {!ext, 4'h4};
      8'h73, 8'h2E: r = {!ext, 4'h5};
      8'h74, 8'h36: r = {!ext, 4'h6};
      8'h6C, 8'h3D: r = {!ext, 4'h7};
      8'h75, 8'h3E: r = {!ext, 4'h8};
      8'h7D, 8'h46: r = {!ext, 4'h9};
      8'h79:        r = {!ext, 4'hA};
      8'h7B:        r = {!ext, 4'hB};
      8'h7C:        r = {!ext, 4'hC};
      8'h4A:        r = {1'b1, 4'hD};
      8'h5A:        r = {1'b1, 4'hE};
      8'h29:        r = {!ext, 4'hF};
      default:      r = 5'h00;
    endcase
    return r;
  endfunction

  // ---- stage p0: falling-edge detect on the receiver strobe ----
  logic       rdy_q;
  logic       accept_p0;
  logic [7:0] byte_p0;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) rdy_q <= 1'b1;
    else         rdy_q <= bus.iREADY_n;
  end

  assign accept_p0 = rdy_q && !bus.iREADY_n;
  assign byte_p0   = bus.iBYTE;

  // ---- stage p0: prefix FSM and timeout ----
  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          timeout;
  logic          make_ev, brk_ev, ev_ext;

  assign timeout = (state != IDLE) && (tmo_cnt == TW'(PREFIX_TIMEOUT - 1));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)                           tmo_cnt <= '0;
    else if (state == IDLE || accept_p0)   tmo_cnt <= '0;
    else if (!timeout)                     tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_comb begin
    state_nxt = state;
    if (accept_p0) begin
      unique case (state)
        IDLE: begin
          if (byte_p0 == 8'hE0)      state_nxt = EXT;
          else if (byte_p0 == 8'hF0) state_nxt = BRK;
        end
        EXT: begin
          if (byte_p0 == 8'hF0)      state_nxt = EXT_BRK;
          else if (byte_p0 != 8'hE0) state_nxt = IDLE;
        end
        BRK, EXT_BRK: state_nxt = IDLE;
        default:      state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;
    unique case (state)
      IDLE:    make_ev = accept_p0 && byte_p0 != 8'hE0 && byte_p0 != 8'hF0;
      EXT: begin
        make_ev = accept_p0 && byte_p0 != 8'hE0 && byte_p0 != 8'hF0;
        ev_ext  = 1'b1;
      end
      BRK:     brk_ev = accept_p0;
      EXT_BRK: begin
        brk_ev = accept_p0;
        ev_ext = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- stage p0: token mapping and held-key tracking ----
  logic [8:0] key_p0;
  logic [4:0] tok_p0;
  logic       repeat_p0;
  logic       push_req;
  logic       held_vld;
  logic [8:0] held_key;

  assign key_p0    = {ev_ext, byte_p0};
  assign tok_p0    = map_token(byte_p0, ev_ext);
  assign repeat_p0 = (SUPPRESS_REPEAT != 0) && held_vld && (held_key == key_p0);
  assign push_req  = make_ev && tok_p0[4] && !repeat_p0;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      held_vld <= 1'b0;
      held_key <= '0;
    end else if (push_req) begin
      held_vld <= 1'b1;
      held_key <= key_p0;
    end else if (brk_ev && held_vld && held_key == key_p0) begin
      held_vld <= 1'b0;
    end
  end

  // ---- stage p1: token FIFO with registered head ----
  logic [4:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CNTW-1:0] count, count_nxt;
  logic            pop_do, push_do, full;
  logic [4:0]      push_data, head_nxt;
  logic            vld_p1;
  logic [3:0]      code_p1;
  logic            ext_p1;
  logic            ovf_q;

  assign full      = (count == CNTW'(FIFO_DEPTH));
  assign pop_do    = bus.iKEY_POP && (count != '0);
  assign push_do   = push_req && (!full || pop_do);
  assign push_data = {tok_p0[3:0], ev_ext};
  assign rd_nxt    = pop_do ? rd_ptr + PW'(1) : rd_ptr;

  always_comb begin
    count_nxt = count;
    if (push_do && !pop_do)      count_nxt = count + CNTW'(1);
    else if (!push_do && pop_do) count_nxt = count - CNTW'(1);
  end

  // The new entry is the head only when the queue is empty after this cycle's pop.
  assign head_nxt = (push_do && wr_ptr == rd_nxt) ? push_data : mem[rd_nxt];

  always_ff @(posedge iCLK) begin
    if (push_do) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      code_p1 <= '0;
      ext_p1  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_do) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      vld_p1 <= (count_nxt != '0);
      if (count_nxt != '0) begin
        code_p1 <= head_nxt[4:1];
        ext_p1  <= head_nxt[0];
      end else begin
        code_p1 <= '0;
        ext_p1  <= 1'b0;
      end
      if (push_req && full && !pop_do) ovf_q <= 1'b1;
    end
  end

  assign bus.oKEY_VALID = vld_p1;
  assign bus.oKEY_CODE  = code_p1;
  assign bus.oKEY_EXT   = ext_p1;
  assign bus.oHELD      = held_vld;
  assign bus.oOVF       = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; two instances differ only in repeat suppression.
module tb_ps2_key_decoder;

  localparam int PT = 20;

  logic       clk;
  logic       rst_n;
  logic       rdy_n;
  logic [7:0] byte_v;
  logic       pop;
  int         checks;
  int         errors;

  ps2_key_decoder_if bus_a ();
  ps2_key_decoder_if bus_b ();

  assign bus_a.iREADY_n = rdy_n;
  assign bus_a.iBYTE    = byte_v;
  assign bus_a.iKEY_POP = pop;
  assign bus_b.iREADY_n = rdy_n;
  assign bus_b.iBYTE    = byte_v;
  assign bus_b.iKEY_POP = pop;

  ps2_key_decoder #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(PT), .SUPPRESS_REPEAT(1)) dut_a (
    .iCLK(clk), .iRST_n(rst_n), .bus(bus_a.slave)
  );

  ps2_key_decoder #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(PT), .SUPPRESS_REPEAT(0)) dut_b (
    .iCLK(clk), .iRST_n(rst_n), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_v = b;
    rdy_n  = 1'b0;
    @(negedge clk);
    rdy_n  = 1'b1;
    @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD, bus_a.oOVF} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 00",
               {bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD, bus_a.oOVF});
    end
  endtask

  task automatic test_make_break();
    do_reset();
    send_byte(8'h69);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD} !== {1'b1, 4'h1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL t1_make got %b exp 1000101",
               {bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD});
    end
    send_byte(8'hF0);
    send_byte(8'h69);
    checks++;
    if (bus_a.oHELD !== 1'b0) begin
      errors++;
      $display("FAIL t1_held_clear got %b exp 0", bus_a.oHELD);
    end
    pop_one();
    checks++;
    if (bus_a.oKEY_VALID !== 1'b0) begin
      errors++;
      $display("FAIL t1_empty got %b exp 0", bus_a.oKEY_VALID);
    end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h5A);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD} !== {1'b1, 4'hE, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL t2_make got %b exp 1111011",
               {bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD});
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    checks++;
    if (bus_a.oHELD !== 1'b0) begin
      errors++;
      $display("FAIL t2_held_clear got %b exp 0", bus_a.oHELD);
    end
    pop_one();
    checks++;
    if (bus_a.oKEY_VALID !== 1'b0) begin
      errors++;
      $display("FAIL t2_no_break_token got %b exp 0", bus_a.oKEY_VALID);
    end
  endtask

  task automatic test_repeat();
    logic [7:0] seq [5];
    seq = '{8'h73, 8'h73, 8'h73, 8'hF0, 8'h73};
    do_reset();
    foreach (seq[i]) send_byte(seq[i]);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE} !== {1'b1, 4'h5}) begin
      errors++;
      $display("FAIL t3_sup_head got %b exp 10101", {bus_a.oKEY_VALID, bus_a.oKEY_CODE});
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus_b.oKEY_VALID, bus_b.oKEY_CODE} !== {1'b1, 4'h5}) begin
        errors++;
        $display("FAIL t3_nosup_tok%0d got %b exp 10101", i, {bus_b.oKEY_VALID, bus_b.oKEY_CODE});
      end
      pop_one();
      if (i == 0) begin
        checks++;
        if (bus_a.oKEY_VALID !== 1'b0) begin
          errors++;
          $display("FAIL t3_sup_single got %b exp 0", bus_a.oKEY_VALID);
        end
      end
    end
    checks++;
    if (bus_b.oKEY_VALID !== 1'b0) begin
      errors++;
      $display("FAIL t3_nosup_count got %b exp 0", bus_b.oKEY_VALID);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] fill [12];
    logic [3:0] exp_tok [4];
    fill    = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26, 8'h25, 8'hF0, 8'h25};
    exp_tok = '{4'h2, 4'h3, 4'h4, 4'h7};
    do_reset();
    foreach (fill[i]) send_byte(fill[i]);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oOVF} !== {1'b1, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL t4_full_no_ovf got %b exp 100010", {bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oOVF});
    end
    send_byte(8'h2E);
    send_byte(8'hF0);
    send_byte(8'h2E);
    send_byte(8'h36);
    checks++;
    if (bus_a.oOVF !== 1'b1) begin
      errors++;
      $display("FAIL t4_ovf got %b exp 1", bus_a.oOVF);
    end
    // push of 3D lands on the same edge as a pop of the full queue
    @(negedge clk);
    byte_v = 8'h3D;
    rdy_n  = 1'b0;
    pop    = 1'b1;
    @(negedge clk);
    rdy_n  = 1'b1;
    pop    = 1'b0;
    @(negedge clk);
    foreach (exp_tok[i]) begin
      checks++;
      if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE} !== {1'b1, exp_tok[i]}) begin
        errors++;
        $display("FAIL t4_tok%0d got %b exp %b", i, {bus_a.oKEY_VALID, bus_a.oKEY_CODE}, {1'b1, exp_tok[i]});
      end
      pop_one();
    end
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oOVF} !== 2'b01) begin
      errors++;
      $display("FAIL t4_drained got %b exp 01", {bus_a.oKEY_VALID, bus_a.oOVF});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hF0);
    repeat (PT + 3) @(negedge clk);
    send_byte(8'h7A);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oHELD} !== {1'b1, 4'h3, 1'b1}) begin
      errors++;
      $display("FAIL t5_after_timeout got %b exp 100111", {bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oHELD});
    end
    pop_one();
    send_byte(8'hF0);
    repeat (3) @(negedge clk);
    send_byte(8'h7A);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oHELD} !== 2'b00) begin
      errors++;
      $display("FAIL t5_break_in_time got %b exp 00", {bus_a.oKEY_VALID, bus_a.oHELD});
    end
  endtask

  task automatic test_reset_mid_and_hold();
    do_reset();
    send_byte(8'h16);
    send_byte(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD, bus_a.oOVF} !== 8'h00) begin
      errors++;
      $display("FAIL t6_in_reset got %h exp 00",
               {bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT, bus_a.oHELD, bus_a.oOVF});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h72);
    checks++;
    if ({bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT} !== {1'b1, 4'h2, 1'b0}) begin
      errors++;
      $display("FAIL t6_prefix_discard got %b exp 100100", {bus_a.oKEY_VALID, bus_a.oKEY_CODE, bus_a.oKEY_EXT});
    end
    @(negedge clk);
    byte_v = 8'h74;
    rdy_n  = 1'b0;
    repeat (10) @(negedge clk);
    rdy_n  = 1'b1;
    @(negedge clk);
    pop_one();
    checks++;
    if ({bus_b.oKEY_VALID, bus_b.oKEY_CODE} !== {1'b1, 4'h6}) begin
      errors++;
      $display("FAIL t6_hold_tok got %b exp 10110", {bus_b.oKEY_VALID, bus_b.oKEY_CODE});
    end
    pop_one();
    checks++;
    if (bus_b.oKEY_VALID !== 1'b0) begin
      errors++;
      $display("FAIL t6_single_accept got %b exp 0", bus_b.oKEY_VALID);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rdy_n  = 1'b1;
    byte_v = 8'h00;
    pop    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_make_break();
    test_extended();
    test_repeat();
    test_overflow();
    test_timeout();
    test_reset_mid_and_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
